// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data-memory responder for the core's load/store path; optional error checking under DMEM_ERR_EN.
// Latency: a store responds 1 cycle after acceptance, a load READ_LATENCY cycles after acceptance; one transaction in flight.
// Backpressure: req_ready is low outside IDLE, and the response is held stable until resp_ready.
module dmem_responder #(
  parameter int DEPTH_WORDS  = 64,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       element1,
  input  logic [31:0]       element2,
  input  logic [31:0]       element3,
  input  logic [31:0]       element4,
  input  logic [31:0]       element5,
  input  logic [31:0]       element6,
  input  logic [31:0]       element7,
  input  logic [31:0]       element8,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int          IDX_W  = $clog2(DEPTH_WORDS);
  localparam int          MEM_W  = DEPTH_WORDS * 32;
  localparam logic [2:0]  LAT_M1 = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                              r_state;
  state_t                              w_next_state;
  logic                                r_live;
  logic [IDX_W-1:0]                    r_idx;
  logic [2:0]                          r_cnt;
  logic [31:0]                         r_rdata;
  logic                                r_err;
  logic [DEPTH_WORDS-1:0][31:0]        r_mem;

  logic [IDX_W-1:0]                    w_idx;
  logic                                w_req_err;
  logic                                w_accept;
  logic                                w_store_en;

  // Word index: byte address with the low two bits dropped, wrapped to the store depth.
  assign w_idx = req_addr[IDX_W+1:2];

`ifdef DMEM_ERR_EN
  // Misaligned or beyond the last word: flagged, never wrapped.
  assign w_req_err = (req_addr[1:0] != 2'b00) ||
                     ((req_addr >> (IDX_W + 2)) != '0);
`else
  assign w_req_err = 1'b0;
  // Ignored address bits: they only matter when error checking is built in.
  logic w_unused_addr;
  assign w_unused_addr = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
`endif

  assign w_accept   = req_valid && req_ready;
  assign w_store_en = w_accept && req_write && !w_req_err;

  // Next-state and handshake outputs; req_ready waits for the first edge after reset.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = r_live;
        if (req_valid && r_live) begin
          if (req_write || (READ_LATENCY == 1)) begin
            w_next_state = S_RESP;
          end else begin
            w_next_state = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == 3'd1) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latch, latency counter and response data; rdata stays 0 for stores and errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live  <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx   <= w_idx;
            r_err   <= w_req_err;
            r_cnt   <= LAT_M1;
            r_rdata <= '0;
            if (!req_write && (READ_LATENCY == 1) && !w_req_err) begin
              r_rdata <= r_mem[w_idx];
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 3'd1;
          if ((r_cnt == 3'd1) && !r_err) begin
            r_rdata <= r_mem[r_idx];
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Backing store: words 0..7 seeded from the element inputs during reset, the rest cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem <= MEM_W'({element8, element7, element6, element5,
                       element4, element3, element2, element1});
    end else if (w_store_en) begin
      r_mem[w_idx] <= req_wdata;
    end
  end

  assign resp_rdata = r_rdata;

`ifdef DMEM_ERR_EN
  assign resp_err = r_err;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of reset seeding, load/store latency, backpressure, wrap/error, mid-load reset.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// The bench finishes on its own; every response wait is bounded.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] element1, element2, element3, element4;
  logic [31:0] element5, element6, element7, element8;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  dmem_responder #(
    .DEPTH_WORDS (64),
    .READ_LATENCY(2),
    .ADDR_W      (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .element1  (element1),
    .element2  (element2),
    .element3  (element3),
    .element4  (element4),
    .element5  (element5),
    .element6  (element6),
    .element7  (element7),
    .element8  (element8),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete request/response with resp_ready held high.
  task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input int exp_lat, input logic exp_err);
    int lat;
    chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 12) begin
      step();
      lat++;
    end
    chk({tag, ".lat"},   32'(lat),      32'(exp_lat));
    chk({tag, ".rdata"}, resp_rdata,    exp_rd);
    chk({tag, ".err"},   32'(resp_err), 32'(exp_err));
    step();
    chk({tag, ".vld_drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    element1   = 32'h11; element2 = 32'h22; element3 = 32'h33; element4 = 32'h44;
    element5   = 32'h55; element6 = 32'h66; element7 = 32'h77; element8 = 32'h88;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;

    // Reset state.
    step();
    step();
    chk("rst.req_ready",  32'(req_ready),  32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_rdata", resp_rdata,      32'd0);
    chk("rst.resp_err",   32'(resp_err),   32'd0);
    reset = 1'b1;
    chk("rel.req_ready_before_edge", 32'(req_ready), 32'd0);
    step();
    chk("rel.req_ready_after_edge", 32'(req_ready), 32'd1);

    // Seeded words.
    xact("ld0",  1'b0, 32'h0,  32'h0, 32'h11, 2, 1'b0);
    xact("ld4",  1'b0, 32'h4,  32'h0, 32'h22, 2, 1'b0);
    xact("ld1c", 1'b0, 32'h1C, 32'h0, 32'h88, 2, 1'b0);

    // Store then load back.
    xact("st20", 1'b1, 32'h20, 32'hDEADBEEF, 32'h0,        1, 1'b0);
    xact("ld20", 1'b0, 32'h20, 32'h0,        32'hDEADBEEF, 2, 1'b0);

    // Response backpressure on a load of word 1.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'h4;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp.resp_valid", 32'(resp_valid), 32'd1);
      chk("bp.resp_rdata", resp_rdata,      32'h22);
      chk("bp.req_ready",  32'(req_ready),  32'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    chk("bp.vld_drop",  32'(resp_valid), 32'd0);
    chk("bp.req_ready", 32'(req_ready),  32'd1);

    // Out-of-range and misaligned addresses.
`ifdef DMEM_ERR_EN
    xact("st100", 1'b1, 32'h100, 32'h5A, 32'h0,  1, 1'b1);
    xact("ld0w",  1'b0, 32'h0,   32'h0,  32'h11, 2, 1'b0);
    xact("ld5",   1'b0, 32'h5,   32'h0,  32'h0,  2, 1'b1);
    xact("ld104", 1'b0, 32'h104, 32'h0,  32'h0,  2, 1'b1);
`else
    xact("st100", 1'b1, 32'h100, 32'h5A, 32'h0,  1, 1'b0);
    xact("ld0w",  1'b0, 32'h0,   32'h0,  32'h5A, 2, 1'b0);
    xact("ld5",   1'b0, 32'h5,   32'h0,  32'h22, 2, 1'b0);
    xact("ld104", 1'b0, 32'h104, 32'h0,  32'h22, 2, 1'b0);
`endif

    // Reset in the BUSY cycle of a load; word 2 was overwritten first.
    xact("st8", 1'b1, 32'h8, 32'h12345678, 32'h0, 1, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h8;
    step();
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    chk("mid.resp_valid", 32'(resp_valid), 32'd0);
    chk("mid.req_ready",  32'(req_ready),  32'd0);
    step();
    step();
    reset = 1'b1;
    chk("mid.req_ready_before_edge", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid.no_resp", 32'(resp_valid), 32'd0);
    end
    chk("mid.req_ready_after", 32'(req_ready), 32'd1);
    xact("ld8_reseed", 1'b0, 32'h8, 32'h0, 32'h33, 2, 1'b0);
    xact("ld0_reseed", 1'b0, 32'h0, 32'h0, 32'h11, 2, 1'b0);

    // Store presented during RESP is ignored.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'h4;
    step();
    step();
    chk("ign.in_resp", 32'(resp_valid), 32'd1);
    req_write = 1'b1;
    req_addr  = 32'h0;
    req_wdata = 32'hCAFEF00D;
    step();
    chk("ign.req_ready", 32'(req_ready), 32'd0);
    step();
    chk("ign.rdata_held", resp_rdata, 32'h22);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    chk("ign.vld_drop", 32'(resp_valid), 32'd0);
    xact("ign.ld0",  1'b0, 32'h0, 32'h0,        32'h11,       2, 1'b0);
    xact("ign.st0",  1'b1, 32'h0, 32'hCAFEF00D, 32'h0,        1, 1'b0);
    xact("ign.ld0b", 1'b0, 32'h0, 32'h0,        32'hCAFEF00D, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
